imm_decode_queue: RTL

//  ID-stage front end that sequences the immediate generator. It accepts fetched

---
 rtl/imm_decode_queue_pkg.sv | 33 +++
 rtl/imm_decode_queue_opcode_classifier.sv | 25 ++
 rtl/imm_decode_queue.sv | 129 ++++++++++++
 3 files changed

// File: rtl/imm_decode_queue_pkg.sv
// Shared constants for the ID-stage immediate decode queue: immediate types,
// RV32 major opcodes, queue state encodings and the stored decode record.
package imm_decode_queue_pkg;

  localparam logic [2:0] RTYPE = 3'd0;
  localparam logic [2:0] ITYPE = 3'd1;
  localparam logic [2:0] STYPE = 3'd2;
  localparam logic [2:0] BTYPE = 3'd3;
  localparam logic [2:0] UTYPE = 3'd4;
  localparam logic [2:0] JTYPE = 3'd5;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_e;

  typedef struct packed {
    logic [24:0] imm_in;
    logic [2:0]  imm_type;
  } dec_t;

endpackage

// File: rtl/imm_decode_queue_opcode_classifier.sv
// Combinational opcode -> immediate-type classifier; unknown opcodes map to
// RTYPE with the illegal flag raised.
module opcode_classifier
  import imm_decode_queue_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_type,
  output logic       illegal
);

  always_comb begin
    imm_type = RTYPE;
    illegal  = 1'b0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: imm_type = ITYPE;
      OP_STORE:                 imm_type = STYPE;
      OP_BRANCH:                imm_type = BTYPE;
      OP_LUI, OP_AUIPC:         imm_type = UTYPE;
      OP_JAL:                   imm_type = JTYPE;
      OP_REG:                   imm_type = RTYPE;
      default:                  illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_decode_queue.sv
// 2-entry skid queue in front of the immediate generator. Classification is
// done on the write path and stored with the entry. Optional macro:
// ILLEGAL_TRAP_EN (store and present the illegal-opcode bit).
module imm_decode_queue
  import imm_decode_queue_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [24:0]     out_imm_in,
  output logic [2:0]      out_imm_type,
  output logic [PC_W-1:0] out_pc,
  output logic            out_illegal
);

  q_state_e        state;
  logic            head, tail;
  dec_t            ent_q [DEPTH];
  logic [PC_W-1:0] pc_q  [DEPTH];

  logic       accept, pop;
  logic [2:0] wr_type;
  logic       wr_illegal;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  opcode_classifier u_cls (
    .opcode   (in_instr[6:0]),
    .imm_type (wr_type),
    .illegal  (wr_illegal)
  );

  // Storage: write at tail, read at head. Only the tail slot is written, so
  // a stalled head never changes underneath EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
        pc_q[i]  <= '0;
      end
    end else if (!flush && accept) begin
      ent_q[tail] <= '{imm_in: in_instr[31:7], imm_type: wr_type};
      pc_q[tail]  <= in_pc;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic ill_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ill_q[i] <= 1'b0;
    end else if (!flush && accept) begin
      ill_q[tail] <= wr_illegal;
    end
  end

  assign out_illegal = out_valid & ill_q[head];
`else
  logic unused_illegal;
  assign unused_illegal = wr_illegal;
  assign out_illegal    = 1'b0;
`endif

  // Control FSM. in_ready/out_valid are registered alongside the state so
  // in_ready has no combinational path from out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= Q_EMPTY;
      head      <= 1'b0;
      tail      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= Q_EMPTY;
      head      <= 1'b0;
      tail      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      if (accept) tail <= ~tail;
      if (pop)    head <= ~head;
      case (state)
        Q_EMPTY: begin
          if (accept) begin
            state     <= Q_ONE;
            out_valid <= 1'b1;
          end
          in_ready <= 1'b1;
        end
        Q_ONE: begin
          if (accept && !pop) begin
            state    <= Q_FULL;
            in_ready <= 1'b0;
          end else if (pop && !accept) begin
            state     <= Q_EMPTY;
            out_valid <= 1'b0;
          end
        end
        Q_FULL: begin
          if (pop) begin
            state    <= Q_ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= Q_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_imm_in   = ent_q[head].imm_in;
  assign out_imm_type = ent_q[head].imm_type;
  assign out_pc       = pc_q[head];

endmodule
